uart_tx_drain: RTL

UART transmitter that drains the 8-bit TX FIFO. Whenever the FIFO is non-empty and the transmitter is idle, it pops one byte and serialises it onto `tx` as an 8N1 frame at a fixed baud rate. It sits between the TX FIFO's pop side (`pop`, `empty`, `pop_data`) and the board's UART TX pin.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_baud_tick.sv | 42 ++++
 rtl/uart_tx_drain.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// =============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: state encoding, data width and the
//                clocks-per-bit calculation used by both TX and RX paths.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = IDLE,
        S_START  = START,
        S_DATA   = DATA,
        S_STOP   = STOP,
        S_PARITY = PARITY
    } tx_state_e;

    // Integer division: any remainder becomes a small baud-rate error.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// =============================================================================
//  Module      : uart_baud_tick
//  Description : Free-running 0..DIV-1 counter with synchronous clear; emits a
//                one-cycle tick on the terminal count.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_drain.sv
// =============================================================================
//  Module      : uart_tx_drain
//  Description : Pops bytes from the TX FIFO whenever idle and serialises them
//                as 8N1 frames; define UART_TX_PARITY_EN for an even-parity bit.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int         DIV      = calc_div(CLK_HZ, BAUD);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e            state_q;
    tx_state_e            state_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [2:0]           bit_idx_q;
    logic [2:0]           bit_idx_d;
    logic                 tx_q;
    logic                 tx_d;
    logic                 done_q;
    logic                 done_d;
    logic                 tick;
    logic                 baud_clr;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
    logic                 par_d;
`endif

    // Held clear in IDLE and on every state change so each state gets a full DIV.
    assign baud_clr = (state_d != state_q) || (state_q == S_IDLE);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;
        fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !rst) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_data;
                    bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                    par_d     = ^fifo_data;
`endif
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level follows the next state so tx is a clean register output.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_done = done_q;
    assign tx_busy = (state_q != S_IDLE);

endmodule

`default_nettype wire
